// File: rtl/frequency_display_driver_pkg.sv
// Shared definitions for the frequency display driver.
// Holds the digit count, the controller state encoding, the active-low
// 7-segment codes (bit6..bit0 = g..a) and the nibble-to-segment decoder.
package frequency_display_driver_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Non-decimal nibbles cannot come out of the converter; blank them anyway.
  function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
    case (nibble)
      4'd0:    seg7_decode = SEG_0;
      4'd1:    seg7_decode = SEG_1;
      4'd2:    seg7_decode = SEG_2;
      4'd3:    seg7_decode = SEG_3;
      4'd4:    seg7_decode = SEG_4;
      4'd5:    seg7_decode = SEG_5;
      4'd6:    seg7_decode = SEG_6;
      4'd7:    seg7_decode = SEG_7;
      4'd8:    seg7_decode = SEG_8;
      4'd9:    seg7_decode = SEG_9;
      default: seg7_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/frequency_display_driver_if.sv
// Bundle between the frequency control block and the display driver.
//   frequency_in / scale_in : current frequency code and step scale (0..3)
//   hex0..hex3              : active-low segments, hex0 = units
//   busy / update_pulse     : conversion in progress / new digits loaded
// master = frequency controller side, slave = display driver.
interface frequency_display_driver_if #(
  parameter int W = 13
);
  logic [W-1:0] frequency_in;
  logic [1:0]   scale_in;
  logic [6:0]   hex0;
  logic [6:0]   hex1;
  logic [6:0]   hex2;
  logic [6:0]   hex3;
  logic         busy;
  logic         update_pulse;

  modport master (
    output frequency_in, scale_in,
    input  hex0, hex1, hex2, hex3, busy, update_pulse
  );

  modport slave (
    input  frequency_in, scale_in,
    output hex0, hex1, hex2, hex3, busy, update_pulse
  );
endinterface

// File: rtl/frequency_display_driver_bin2bcd_serial.sv
// Serial double-dabble binary to 4-digit BCD converter, one bit per cycle.
//   i_start : load i_value and begin (ignored while o_busy is low only in intent;
//             a start always restarts the conversion)
//   o_busy  : conversion running
//   o_done  : strobe during the cycle whose clock edge performs the last shift,
//             so o_bcd holds the result from the following cycle on
//   o_bcd   : {thousands, hundreds, tens, units}, held until the next start
module frequency_display_driver_bin2bcd_serial
  import frequency_display_driver_pkg::*;
#(
  parameter int W = 13
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_start,
  input  logic [W-1:0]            i_value,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [4*NUM_DIGITS-1:0] o_bcd
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]            r_shift;
  logic [4*NUM_DIGITS-1:0] r_bcd;
  logic [CW-1:0]           r_count;
  logic                    r_busy;
  logic [4*NUM_DIGITS-1:0] w_adj;

  // Add-3 correction on every nibble that would overflow past 9 when doubled.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end else begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4];
      end
    end
  end

  // Load on start, then shift {bcd, shift} left once per cycle for W cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
      r_bcd   <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
    end else if (i_start) begin
      r_shift <= i_value;
      r_bcd   <= '0;
      r_count <= CW'(W);
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      r_bcd   <= {w_adj[4*NUM_DIGITS-2:0], r_shift[W-1]};
      r_shift <= {r_shift[W-2:0], 1'b0};
      r_count <= r_count - CW'(1);
      if (r_count == CW'(1)) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_count == CW'(1));
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/frequency_display_driver.sv
// Frequency display driver: watches the frequency code, converts it to four
// BCD digits and drives four active-low 7-segment displays. The digit that
// the current scale steps blinks at BLINK_HZ.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of frequency_display_driver_if
module frequency_display_driver
  import frequency_display_driver_pkg::*;
#(
  parameter int FREQUENCY_RANGE = 8192,
  parameter int CLK_FREQ_HZ     = 50000000,
  parameter int BLINK_HZ        = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  frequency_display_driver_if.slave   bus
);
  localparam int W    = $clog2(FREQUENCY_RANGE);
  localparam int HALF = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

  state_t                  r_state;
  logic                    r_init_pending;
  logic [W-1:0]            r_captured;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic                    r_busy;
  logic                    r_update_pulse;
  logic [BW-1:0]           r_blink_cnt;
  logic                    r_blink_phase;
  logic [1:0]              r_scale;
  logic [6:0]              r_hex [NUM_DIGITS];

  logic                    w_start;
  logic                    w_conv_busy;
  logic                    w_conv_done;
  logic [4*NUM_DIGITS-1:0] w_bcd;
  logic [BW-1:0]           w_cnt_next;
  logic                    w_phase_next;

  // Inputs are only sampled in IDLE; a change during a conversion is picked
  // up by this compare once the FSM returns.
  assign w_start = (r_state == IDLE) &&
                   (r_init_pending || (bus.frequency_in != r_captured));

  frequency_display_driver_bin2bcd_serial #(.W(W)) u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_start),
    .i_value (bus.frequency_in),
    .o_busy  (w_conv_busy),
    .o_done  (w_conv_done),
    .o_bcd   (w_bcd)
  );

  // Conversion controller: change detection, handshake, digit load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_init_pending <= 1'b1;
      r_captured     <= '0;
      r_digits       <= '0;
      r_busy         <= 1'b0;
      r_update_pulse <= 1'b0;
    end else begin
      r_update_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_captured     <= bus.frequency_in;
            r_init_pending <= 1'b0;
            r_busy         <= 1'b1;
            r_state        <= CONVERT;
          end
        end
        CONVERT: begin
          // A converter that is unexpectedly idle also ends the wait.
          if (w_conv_done || !w_conv_busy) begin
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_digits       <= w_bcd;
          r_update_pulse <= 1'b1;
          r_busy         <= 1'b0;
          r_state        <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Next blink state; a scale change restarts the visible half-period.
  always_comb begin
    if (bus.scale_in != r_scale) begin
      w_cnt_next   = '0;
      w_phase_next = 1'b0;
    end else if (r_blink_cnt == BW'(HALF - 1)) begin
      w_cnt_next   = '0;
      w_phase_next = ~r_blink_phase;
    end else begin
      w_cnt_next   = r_blink_cnt + BW'(1);
      w_phase_next = r_blink_phase;
    end
  end

  // Blink counter, phase and the registered copy of scale_in.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_scale       <= 2'd0;
    end else begin
      r_blink_cnt   <= w_cnt_next;
      r_blink_phase <= w_phase_next;
      r_scale       <= bus.scale_in;
    end
  end

  // Output stage uses the next blink phase so the displays track the phase
  // register exactly, including the forced-visible cycle after a scale change.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_hex[i] <= SEG_BLANK;
      end
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_phase_next && (bus.scale_in == 2'(i))) begin
          r_hex[i] <= SEG_BLANK;
        end else begin
          r_hex[i] <= seg7_decode(r_digits[4*i +: 4]);
        end
      end
    end
  end

  assign bus.hex0         = r_hex[0];
  assign bus.hex1         = r_hex[1];
  assign bus.hex2         = r_hex[2];
  assign bus.hex3         = r_hex[3];
  assign bus.busy         = r_busy;
  assign bus.update_pulse = r_update_pulse;

endmodule

// File: tb/tb_frequency_display_driver.sv
module tb_frequency_display_driver;
  localparam int W    = 13;
  localparam int HALF = 4;

  logic clk;
  logic reset;

  frequency_display_driver_if #(.W(W))  bus ();
  frequency_display_driver_if #(.W(14)) bus14 ();

  frequency_display_driver #(
    .FREQUENCY_RANGE (8192),
    .CLK_FREQ_HZ     (8),
    .BLINK_HZ        (1)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  frequency_display_driver #(
    .FREQUENCY_RANGE (10000),
    .CLK_FREQ_HZ     (100000),
    .BLINK_HZ        (1)
  ) u_dut14 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus14)
  );

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int pulse_cnt  = 0;

  logic [15:0] sb [$];
  logic [15:0] cur        = 16'd0;
  logic [15:0] pend       = 16'd0;
  logic        pend_valid = 1'b0;
  int          blink_n    = 0;
  logic [1:0]  prev_scale = 2'd0;
  logic [1:0]  exp_scale  = 2'd0;
  logic        rst_seen   = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: seg_of = 7'h40;  1: seg_of = 7'h79;  2: seg_of = 7'h24;
      3: seg_of = 7'h30;  4: seg_of = 7'h19;  5: seg_of = 7'h12;
      6: seg_of = 7'h02;  7: seg_of = 7'h78;  8: seg_of = 7'h00;
      9: seg_of = 7'h10;  default: seg_of = 7'h7F;
    endcase
  endfunction

  function automatic logic [15:0] bcd_of(input int v);
    bcd_of = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Blink model: edges since the last reset/scale change, phase = (n/HALF) mod 2.
  always @(posedge clk) begin
    if (reset) begin
      blink_n    <= 0;
      prev_scale <= 2'd0;
      rst_seen   <= 1'b1;
    end else begin
      rst_seen   <= 1'b0;
      blink_n    <= (bus.scale_in != prev_scale) ? 0 : blink_n + 1;
      prev_scale <= bus.scale_in;
    end
    exp_scale <= bus.scale_in;
  end

  // Scoreboard monitor: digits popped on update_pulse appear on hex one edge later.
  always @(negedge clk) begin : monitor
    logic [15:0] shown;
    logic [6:0]  obs [4];
    logic [6:0]  exp_hex;
    logic        phase;
    obs[0] = bus.hex0; obs[1] = bus.hex1; obs[2] = bus.hex2; obs[3] = bus.hex3;
    if (rst_seen) begin
      cur        <= 16'd0;
      pend_valid <= 1'b0;
      check_eq("hex_blank_in_reset", {bus.hex3, bus.hex2, bus.hex1, bus.hex0}, {4{7'h7F}});
      check_eq("pulse_in_reset", bus.update_pulse, 1'b0);
    end else begin
      shown = pend_valid ? pend : cur;
      cur   <= shown;
      phase = ((blink_n / HALF) % 2) == 1;
      for (int i = 0; i < 4; i++) begin
        if (phase && (exp_scale == 2'(i))) exp_hex = 7'h7F;
        else exp_hex = seg_of(int'(shown[4*i +: 4]));
        check_eq($sformatf("hex%0d", i), obs[i], exp_hex);
      end
      if (bus.update_pulse) begin
        pulse_cnt <= pulse_cnt + 1;
        if (sb.size() == 0) begin
          check_eq("unexpected_pulse", 1'b1, 1'b0);
          pend_valid <= 1'b0;
        end else begin
          pend       <= sb.pop_front();
          pend_valid <= 1'b1;
        end
      end else begin
        pend_valid <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while ((sb.size() != 0 || pend_valid || bus.busy) && t < 300) begin
      tick();
      t++;
    end
    check_eq(tag, (t < 300), 1'b1);
    repeat (2) tick();
  endtask

  task automatic wait_busy(input string tag);
    int t;
    t = 0;
    while (!bus.busy && t < 10) begin
      tick();
      t++;
    end
    check_eq(tag, bus.busy, 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int p0;
    reset              = 1'b1;
    bus.frequency_in   = 13'd0;
    bus.scale_in       = 2'd0;
    bus14.frequency_in = 14'd9999;
    bus14.scale_in     = 2'd0;
    repeat (3) tick();
    check_eq("busy_in_reset", bus.busy, 1'b0);

    // Forced conversion after reset with frequency_in = 0.
    sb.push_back(bcd_of(0));
    reset = 1'b0;
    wait_idle("init_done");
    check_eq("init_pulses", pulse_cnt, 1);
    check_eq("init_hex31", {bus.hex3, bus.hex2, bus.hex1}, {3{7'h40}});
    check_eq("w14_9999", {bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0}, {4{7'h10}});

    // 1234 with hex0 blinking.
    bus.frequency_in = 13'd1234;
    sb.push_back(bcd_of(1234));
    wait_idle("conv_1234");
    check_eq("hex31_1234", {bus.hex3, bus.hex2, bus.hex1}, {7'h79, 7'h24, 7'h30});

    // Full-scale code.
    bus.frequency_in = 13'd8191;
    sb.push_back(bcd_of(8191));
    wait_idle("conv_8191");
    check_eq("hex31_8191", {bus.hex3, bus.hex2, bus.hex1}, {7'h00, 7'h79, 7'h10});

    // Change on the 3rd CONVERT cycle: 0100 shown, then 0200.
    p0 = pulse_cnt;
    bus.frequency_in = 13'd100;
    sb.push_back(bcd_of(100));
    wait_busy("busy_100");
    repeat (2) tick();
    bus.frequency_in = 13'd200;
    sb.push_back(bcd_of(200));
    wait_idle("conv_100_200");
    check_eq("pulses_100_200", pulse_cnt - p0, 2);

    // Scale 0 -> 3 while the blink phase is 1.
    begin
      int t;
      t = 0;
      while (((blink_n / HALF) % 2) != 1 && t < 20) begin
        tick();
        t++;
      end
      check_eq("phase_found", ((blink_n / HALF) % 2), 1);
    end
    bus.scale_in = 2'd3;
    tick();
    check_eq("hex0_after_scale", bus.hex0, 7'h40);
    check_eq("hex3_after_scale", bus.hex3, 7'h40);
    repeat (3) tick();
    check_eq("hex3_still_visible", bus.hex3, 7'h40);
    tick();
    check_eq("hex3_blanked", bus.hex3, 7'h7F);

    // Reset in the middle of a conversion: aborted run never reports.
    bus.frequency_in = 13'd4321;
    wait_busy("busy_4321");
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_eq("busy_abort", bus.busy, 1'b0);
    check_eq("hex_abort", {bus.hex3, bus.hex2, bus.hex1, bus.hex0}, {4{7'h7F}});
    p0 = pulse_cnt;
    sb.push_back(bcd_of(4321));
    reset = 1'b0;
    wait_idle("conv_after_abort");
    check_eq("pulses_after_abort", pulse_cnt - p0, 1);
    check_eq("hex20_4321", {bus.hex2, bus.hex1, bus.hex0}, {7'h30, 7'h24, 7'h79});

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
